// File: rtl/mac_dot16.sv
// Two-stage pipelined signed dot product: 16 registered 8x8 products, then one
// registered sum of four PE partial sums. Fixed 2-clock latency, one result per clock.
module mac_dot16 #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 20
) (
   input  logic             clk,
   input  logic             reset_mul,
   input  logic             reset_add,
   input  logic [IN_W-1:0]  a,  b,  c,  d,  e,  f,  g,  h,
   input  logic [IN_W-1:0]  a1, b1, c1, d1, e1, f1, g1, h1,
   input  logic [IN_W-1:0]  a2, b2, c2, d2, e2, f2, g2, h2,
   input  logic [IN_W-1:0]  a3, b3, c3, d3, e3, f3, g3, h3,
   output logic [OUT_W-1:0] out
);

   localparam int PROD_W = 2 * IN_W;
   localparam int PE_W   = PROD_W + 2;
   localparam int NPAIR  = 16;

   logic signed [IN_W-1:0]   op_x [NPAIR];
   logic signed [IN_W-1:0]   op_y [NPAIR];
   logic signed [PROD_W-1:0] prod [NPAIR];
   logic signed [PE_W-1:0]   pe_sum [4];
   logic signed [OUT_W-1:0]  sum_d;

   // Pair index 4*k+j is pair j of PE k.
   assign op_x[0]  = a;   assign op_y[0]  = b;
   assign op_x[1]  = c;   assign op_y[1]  = d;
   assign op_x[2]  = e;   assign op_y[2]  = f;
   assign op_x[3]  = g;   assign op_y[3]  = h;
   assign op_x[4]  = a1;  assign op_y[4]  = b1;
   assign op_x[5]  = c1;  assign op_y[5]  = d1;
   assign op_x[6]  = e1;  assign op_y[6]  = f1;
   assign op_x[7]  = g1;  assign op_y[7]  = h1;
   assign op_x[8]  = a2;  assign op_y[8]  = b2;
   assign op_x[9]  = c2;  assign op_y[9]  = d2;
   assign op_x[10] = e2;  assign op_y[10] = f2;
   assign op_x[11] = g2;  assign op_y[11] = h2;
   assign op_x[12] = a3;  assign op_y[12] = b3;
   assign op_x[13] = c3;  assign op_y[13] = d3;
   assign op_x[14] = e3;  assign op_y[14] = f3;
   assign op_x[15] = g3;  assign op_y[15] = h3;

   // Operands are sign-extended to full product width, so the low PROD_W bits are exact.
   always_ff @(posedge clk or posedge reset_mul) begin
      if (reset_mul) begin
         // NOTE: this register array is reset element by element because a
         // reset_mul pulse must flush in-flight products, not just the output.
         for (int i = 0; i < NPAIR; i++) prod[i] <= '0;
      end else begin
         // NOTE: non-blocking so every product samples operands of the same edge.
         for (int i = 0; i < NPAIR; i++)
            prod[i] <= PROD_W'(op_x[i]) * PROD_W'(op_y[i]);
      end
   end

   always_comb begin
      // NOTE: every element is assigned on every pass, so no latch is inferred.
      for (int k = 0; k < 4; k++) begin
         pe_sum[k] = PE_W'(prod[4*k])     + PE_W'(prod[4*k + 1])
                   + PE_W'(prod[4*k + 2]) + PE_W'(prod[4*k + 3]);
      end
      sum_d = OUT_W'(pe_sum[0]) + OUT_W'(pe_sum[1])
            + OUT_W'(pe_sum[2]) + OUT_W'(pe_sum[3]);
   end

   always_ff @(posedge clk or posedge reset_add) begin
      if (reset_add) out <= '0;
      else           out <= sum_d;
   end

endmodule

// File: tb/tb_mac_dot16.sv
// Directed and random checks of mac_dot16: async resets, 2-clock latency,
// range extremes, streaming, and a golden-model comparison on random vectors.
module tb_mac_dot16;

   logic        clk = 1'b0;
   logic        reset_mul;
   logic        reset_add;
   logic [7:0]  opv [32];
   logic [19:0] out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mac_dot16 dut (
      .clk(clk), .reset_mul(reset_mul), .reset_add(reset_add),
      .a(opv[0]),   .b(opv[1]),   .c(opv[2]),   .d(opv[3]),
      .e(opv[4]),   .f(opv[5]),   .g(opv[6]),   .h(opv[7]),
      .a1(opv[8]),  .b1(opv[9]),  .c1(opv[10]), .d1(opv[11]),
      .e1(opv[12]), .f1(opv[13]), .g1(opv[14]), .h1(opv[15]),
      .a2(opv[16]), .b2(opv[17]), .c2(opv[18]), .d2(opv[19]),
      .e2(opv[20]), .f2(opv[21]), .g2(opv[22]), .h2(opv[23]),
      .a3(opv[24]), .b3(opv[25]), .c3(opv[26]), .d3(opv[27]),
      .e3(opv[28]), .f3(opv[29]), .g3(opv[30]), .h3(opv[31]),
      .out(out)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int out_val();
      return int'($signed(out));
   endfunction

   function automatic int golden();
      int s = 0;
      for (int i = 0; i < 16; i++)
         s += int'($signed(opv[2*i])) * int'($signed(opv[2*i + 1]));
      return s;
   endfunction

   // Advance one rising edge, then settle 1 time unit before driving/sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [7:0] v);
      for (int i = 0; i < 32; i++) opv[i] = v;
   endtask

   initial begin
      int exp_r;
      reset_mul = 1'b1;
      reset_add = 1'b1;
      set_all(8'd0);
      step();
      step();
      reset_mul = 1'b0;
      reset_add = 1'b0;

      // Get a nonzero result, then assert both resets between edges.
      opv[0] = 8'd3; opv[1] = 8'd5;
      step();
      step();
      check("preload", out_val(), 15);
      set_all(8'h80);
      #2;
      reset_mul = 1'b1;
      reset_add = 1'b1;
      #1;
      check("async_both", out_val(), 0);
      step();
      check("both_held", out_val(), 0);
      reset_mul = 1'b0;
      reset_add = 1'b0;
      set_all(8'd0);
      step();
      step();
      check("zero_ops", out_val(), 0);

      // Single pair: unchanged after 1 edge, result after 2.
      opv[0] = 8'd3; opv[1] = 8'd5;
      step();
      check("single_lat1", out_val(), 0);
      step();
      check("single_lat2", out_val(), 15);

      // Range extremes.
      set_all(8'h80);
      step();
      step();
      check("max_pos", out_val(), 262144);
      for (int i = 0; i < 32; i++) opv[i] = (i % 2 == 0) ? 8'd127 : 8'h80;
      step();
      step();
      check("max_neg", out_val(), -260096);

      // Streaming: a=k, b=1 each clock; out lags by 2 edges.
      set_all(8'd0);
      opv[1] = 8'd1;
      for (int k = 1; k <= 5; k++) begin
         opv[0] = 8'(k);
         step();
         if (k >= 2) check($sformatf("stream_%0d", k - 1), out_val(), k - 1);
      end
      opv[0] = 8'd0;
      step();
      check("stream_5", out_val(), 5);

      // reset_mul pulse mid-stream; out is only zeroed by the following edge.
      set_all(8'd0);
      opv[0] = 8'd7; opv[1] = 8'd9;
      opv[30] = 8'hFE; opv[31] = 8'd4;
      step();
      step();
      check("pre_rmul", out_val(), 55);
      reset_mul = 1'b1;
      #1;
      check("rmul_out_kept", out_val(), 55);
      step();
      check("rmul_edge", out_val(), 0);
      reset_mul = 1'b0;
      step();
      check("rmul_rel1", out_val(), 0);
      step();
      check("rmul_rel2", out_val(), 55);

      // reset_add alone clears out at once; products are untouched.
      reset_add = 1'b1;
      #1;
      check("radd_async", out_val(), 0);
      reset_add = 1'b0;
      step();
      check("radd_rel", out_val(), 55);

      // Random vectors, each held 2 clocks.
      for (int n = 0; n < 100; n++) begin
         for (int i = 0; i < 32; i++) opv[i] = 8'($urandom);
         exp_r = golden();
         step();
         step();
         check($sformatf("rand_%0d", n), out_val(), exp_r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
